// File: rtl/vec_acc_adapter.sv
// Scalar-to-vector accelerator adapter: request FIFO, credit-limited issue and a registered response stage.
// Optional macro VEC_ACC_ILLEGAL_CHK_EN enables local rejection of heads with unsupported opcodes.
module vec_acc_adapter #(
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 4,
    parameter int REQ_DEPTH     = 4,
    parameter int MAX_OUT       = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [32+2*XLEN+TRANS_ID_BITS-1:0]    req_data_i,
    output logic                                  vu_valid_o,
    input  logic                                  vu_ready_i,
    output logic [32+2*XLEN+TRANS_ID_BITS-1:0]    vu_data_o,
    input  logic                                  vu_resp_valid_i,
    output logic                                  vu_resp_ready_o,
    input  logic [1+XLEN+TRANS_ID_BITS-1:0]       vu_resp_data_i,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output logic [1+XLEN+TRANS_ID_BITS-1:0]       resp_data_o,
    output logic [$clog2(MAX_OUT+1)-1:0]          outstanding_o,
    output logic [$clog2(REQ_DEPTH+1)-1:0]        fifo_count_o
);

    localparam int RW = 32 + 2*XLEN + TRANS_ID_BITS;
    localparam int SW = 1 + XLEN + TRANS_ID_BITS;
    localparam int CW = $clog2(REQ_DEPTH+1);
    localparam int OW = $clog2(MAX_OUT+1);
    localparam int PW = $clog2(REQ_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(REQ_DEPTH);
    localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUT);

    logic [RW-1:0] r_mem [REQ_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_out;
    logic          r_resp_valid;
    logic [SW-1:0] r_resp_data;

    logic [RW-1:0] w_head;
    logic          w_empty;
    logic          w_legal;
    logic          w_push;
    logic          w_issue;
    logic          w_vu_resp;
    logic          w_ill;
    logic          w_pop;
    logic          w_dec;

    assign w_head  = r_mem[r_rptr];
    assign w_empty = (r_count == '0);

`ifdef VEC_ACC_ILLEGAL_CHK_EN
    logic [6:0] w_opcode;
    assign w_opcode = w_head[RW-32 +: 7];
    assign w_legal  = (w_opcode == 7'h57) || (w_opcode == 7'h07) || (w_opcode == 7'h27);
    // A vector-unit response wins the response register; the illegal head waits a cycle.
    assign w_ill    = !w_empty && !w_legal && vu_resp_ready_o && !vu_resp_valid_i;
`else
    assign w_legal  = 1'b1;
    assign w_ill    = 1'b0;
`endif

    assign req_ready_o     = (r_count < DEPTH_C);
    assign vu_valid_o      = !w_empty && w_legal && (r_out < MAXO_C);
    assign vu_data_o       = w_head;
    assign vu_resp_ready_o = !r_resp_valid || resp_ready_i;
    assign resp_valid_o    = r_resp_valid;
    assign resp_data_o     = r_resp_data;
    assign outstanding_o   = r_out;
    assign fifo_count_o    = r_count;

    assign w_push    = req_valid_i && req_ready_o;
    assign w_issue   = vu_valid_o && vu_ready_i;
    assign w_vu_resp = vu_resp_valid_i && vu_resp_ready_o;
    assign w_pop     = w_issue || w_ill;
    // A stray response with nothing outstanding must not underflow the credit counter.
    assign w_dec     = w_vu_resp && (r_out != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < REQ_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_out        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= req_data_i;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
            case ({w_issue, w_dec})
                2'b10:   r_out <= r_out + OW'(1);
                2'b01:   r_out <= r_out - OW'(1);
                default: ;
            endcase
            if (w_vu_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= vu_resp_data_i;
            end else if (w_ill) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= {1'b1, {XLEN{1'b0}}, w_head[TRANS_ID_BITS-1:0]};
            end else if (resp_ready_i) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vec_acc_adapter.md
VEC_ACC_ADAPTER -- requirements
Module: vec_acc_adapter

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar operand/result width.
REQ-002 SHALL have parameter TRANS_ID_BITS, default 4, instruction ID width.
REQ-003 SHALL have parameter REQ_DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter MAX_OUT, default 8, maximum instructions outstanding at the vector unit (>=1).
REQ-005 SHALL have a single clock and an asynchronous, active-high reset; all flops clock on clk_i rising edge.
REQ-006 Ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- req_valid_i  in  1  scalar request valid
- req_ready_o  out  1  request accepted when high with valid
- req_data_i  in  32+2*XLEN+TRANS_ID_BITS  packed {instr, rs1, rs2, instr_id}
- vu_valid_o  out  1  issue valid to vector unit
- vu_ready_i  in  1  vector unit accepts issue
- vu_data_o  out  32+2*XLEN+TRANS_ID_BITS  packed {instr, rs1, rs2, instr_id}
- vu_resp_valid_i  in  1  vector unit response valid
- vu_resp_ready_o  out  1  vector unit response accepted
- vu_resp_data_i  in  1+XLEN+TRANS_ID_BITS  packed {err, res, instr_id}
- resp_valid_o  out  1  response valid to scalar core
- resp_ready_i  in  1  scalar core accepts response
- resp_data_o  out  1+XLEN+TRANS_ID_BITS  packed {err, res, instr_id}
- outstanding_o  out  $clog2(MAX_OUT+1)  instructions issued, response not yet accepted
- fifo_count_o  out  $clog2(REQ_DEPTH+1)  request FIFO occupancy

Function
REQ-007 Request FIFO: push on req_valid_i&&req_ready_o; req_ready_o = (count < REQ_DEPTH), no same-cycle bypass when full even if popping.
REQ-008 Entry pushed at edge N SHALL appear at FIFO head no earlier than cycle N+1 (no combinational pass-through).
REQ-009 Read/write pointers SHALL wrap modulo REQ_DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-010 Head is legal iff instr[6:0] is 7'h57, 7'h07 or 7'h27.
REQ-011 vu_valid_o = FIFO non-empty && head legal && outstanding_o < MAX_OUT; vu_data_o = head entry unmodified.
REQ-012 On vu_valid_o&&vu_ready_i: pop head, outstanding +1.
REQ-013 Response stage: single output register; vu_resp_ready_o = !resp_valid_o || resp_ready_i; loads on vu_resp_valid_i&&vu_resp_ready_o (latency 1 cycle), outstanding -1.
REQ-014 Illegal head (see REQ-019): not issued; when response register loadable and vu_resp_valid_i low, load {err=1, res=0, instr_id=head id} and pop head.
REQ-015 Response source priority: vector unit response over illegal-instruction response, same cycle.
REQ-016 resp_valid_o SHALL stay high with stable resp_data_o until resp_ready_i.
REQ-017 Issue and response in same cycle: outstanding unchanged; outstanding SHALL never exceed MAX_OUT; response with outstanding 0 SHALL hold counter at 0.

Reset
REQ-018 While rst_i high: FIFO empty, pointers 0, outstanding 0, response register invalid; req_ready_o=1, vu_valid_o=0, vu_resp_ready_o=1, resp_valid_o=0, resp_data_o=0, counts 0; in-flight entries discarded.

Configuration
REQ-019 Macro VEC_ACC_ILLEGAL_CHK_EN: defined -> REQ-010/REQ-014 active; undefined -> every head treated legal, forwarded to vector unit, no locally generated error responses.

Verification
REQ-020 Fill: 4 requests, vu_ready_i=0 -> fifo_count_o=4, req_ready_o=0, 5th request stalls until one issue.
REQ-021 Credit limit MAX_OUT=8: 10 legal requests, no responses -> exactly 8 issued, outstanding_o=8, vu_valid_o=0 until a response is accepted.
REQ-022 Same-cycle issue and response at outstanding_o=3 -> outstanding_o stays 3.
REQ-023 Macro defined, head instr[6:0]=7'h33 id=5 -> resp_data_o={1,0,5} one cycle later, never seen on vu_valid_o; undefined -> forwarded to vector unit.
REQ-024 Backpressure: resp_ready_i=0 with response held -> vu_resp_ready_o=0, resp_data_o stable; rst_i asserted mid-operation -> all outputs return to REQ-018 values asynchronously.
